// File: rtl/ms_spi_line_reader_pkg.sv
// Shared definitions for the SPI XIP line reader: command byte, address
// width, FSM state encoding and the word byte-order helper.
package ms_spi_pkg;

    localparam int         ADDR_W   = 24;
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        SHIFT = 2'd2,
        DESEL = 2'd3
    } state_t;

    // Bytes arrive MSB-first into a shift register, so the first byte ends
    // up in [31:24]; the cache wants it in [7:0] (little-endian words).
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ms_spi_line_reader_if.sv
// Bundle of the cache-side request/response signals and the flash pins.
//
// Handshake: a request is taken on a rising HCLK edge where req=1 and
// busy=0; req while busy=1 is dropped, not queued. Words come back on
// rvalid with no back-pressure (the consumer must take every pulse);
// done pulses together with the last rvalid of the line.
interface ms_spi_line_reader_if;
    import ms_spi_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              done;
    logic              sck;
    logic              ce_n;
    logic              mosi;
    logic              miso;

    // Cache controller plus flash device side.
    modport master (
        output req, addr, miso,
        input  busy, rdata, rvalid, done, sck, ce_n, mosi
    );

    // Line reader side.
    modport slave (
        input  req, addr, miso,
        output busy, rdata, rvalid, done, sck, ce_n, mosi
    );

endinterface

// File: rtl/ms_spi_line_reader_shifter.sv
// TX/RX shift registers and the SCK phase toggle. While run=1 every HCLK
// edge alternates: raise sck and sample miso, then lower sck and present
// the next mosi bit. Zeros shift in behind the command, so mosi is 0 for
// the data phase without extra gating.
module ms_spi_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        run,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic [31:0] rx_word
);

    logic [31:0] tx_q;

    // Load the command word, then toggle sck and shift on alternate edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q    <= '0;
            rx_word <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
        end else if (load) begin
            tx_q <= load_val;
            mosi <= load_val[31];
            sck  <= 1'b0;
        end else if (run) begin
            if (!sck) begin
                sck     <= 1'b1;
                rx_word <= {rx_word[30:0], miso};
            end else begin
                sck  <= 1'b0;
                tx_q <= {tx_q[30:0], 1'b0};
                mosi <= tx_q[30];
            end
        end
    end

endmodule

// File: rtl/ms_spi_line_reader.sv
// SPI flash line reader: issues Read (0x03) + 24-bit line-aligned address
// and returns LINE_WORDS little-endian 32-bit words, then holds CE# high
// for at least CEH_CYCLES before accepting the next request.
module ms_spi_line_reader
    import ms_spi_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int CEH_CYCLES = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ms_spi_line_reader_if.slave  bus,
    output state_t               state
);

    localparam int TOTAL_BITS = 32 + 32 * LINE_WORDS;
    localparam int CNT_W      = $clog2(TOTAL_BITS);
    localparam int DESEL_W    = $clog2(CEH_CYCLES + 1);

    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0]   FIRST_DATA = CNT_W'(32);
    localparam logic [DESEL_W-1:0] DESEL_LAST = DESEL_W'(CEH_CYCLES);
    localparam logic [ADDR_W-1:0]  LINE_MASK  = ADDR_W'(LINE_WORDS * 4 - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DESEL_W-1:0] desel_cnt;
    logic [ADDR_W-1:0]  line_addr;
    logic               accept;
    logic               run;
    logic               fall;
    logic               last_bit;
    logic               word_end;
    logic               desel_end;
    logic               sck_int;
    logic               mosi_int;
    logic [31:0]        rx_word;

    assign line_addr = bus.addr & ~LINE_MASK;
    assign accept    = (state_q == IDLE) && bus.req;
    assign run       = (state_q == SHIFT);
    // The edge that lowers sck closes one bit period.
    assign fall      = run && sck_int;
    assign last_bit  = (bit_cnt == LAST_BIT);
    // Closing the 32nd bit of any data word (bits 63, 95, ...).
    assign word_end  = fall && (bit_cnt >= FIRST_DATA) && (bit_cnt[4:0] == 5'h1f);
    assign desel_end = (state_q == DESEL) && (desel_cnt == DESEL_LAST);

    ms_spi_shifter u_shifter (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .load     (accept),
        .load_val ({CMD_READ, line_addr}),
        .run      (run),
        .miso     (bus.miso),
        .sck      (sck_int),
        .mosi     (mosi_int),
        .rx_word  (rx_word)
    );

    assign bus.sck  = sck_int;
    assign bus.mosi = mosi_int;
    assign state    = state_q;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: IDLE -> SEL -> SHIFT -> DESEL -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req)           state_d = SEL;
            SEL:                            state_d = SHIFT;
            SHIFT:   if (fall && last_bit)  state_d = DESEL;
            DESEL:   if (desel_end)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Bit/deselect counters, chip enable, busy and the word outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bit_cnt    <= '0;
            desel_cnt  <= '0;
            bus.busy   <= 1'b0;
            bus.ce_n   <= 1'b1;
            bus.rvalid <= 1'b0;
            bus.done   <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= word_end;
            bus.done   <= word_end && last_bit;
            if (word_end) bus.rdata <= byte_swap32(rx_word);

            if (accept) begin
                bit_cnt  <= '0;
                bus.busy <= 1'b1;
                bus.ce_n <= 1'b0;
            end else if (fall) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // First DESEL cycle still has ce_n low with sck already at 0;
            // ce_n rises on the next edge and is then held for CEH_CYCLES.
            if (state_q == DESEL) begin
                bus.ce_n  <= 1'b1;
                desel_cnt <= desel_cnt + DESEL_W'(1);
            end else begin
                desel_cnt <= '0;
            end

            if (desel_end) bus.busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ms_spi_line_reader.sv
// Bench for ms_spi_line_reader: behavioural SPI flash, word scoreboard,
// table-driven line reads, hand-written corner sequences, random reads.
module tb_ms_spi_line_reader;
    import ms_spi_pkg::*;

    localparam int LINE_WORDS = 4;
    localparam int CEH_CYCLES = 2;
    localparam int TOTAL_BITS = 32 + 32 * LINE_WORDS;
    localparam int FIRST_LAT  = 1 + 2 * 64;
    localparam int LAST_LAT   = 1 + 2 * TOTAL_BITS;
    localparam int BUSY_LAT   = LAST_LAT + 1 + CEH_CYCLES;

    // ---------------- clock / reset ----------------
    logic   HCLK    = 1'b0;
    logic   HRESETn = 1'b1;
    state_t state;
    int     cyc     = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    ms_spi_line_reader_if bus ();

    ms_spi_line_reader #(
        .LINE_WORDS (LINE_WORDS),
        .CEH_CYCLES (CEH_CYCLES)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .state   (state)
    );

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    int          sck_rises = 0, bits_in = 0, out_bit = 0, ce_falls = 0;
    int          rvalid_cnt = 0, done_cnt = 0;
    int          hi_run = 0, hi_busy = 0, last_gap = 0, last_gap_busy = 0;
    int          bad_sck = 0, bad_ce = 0;
    int          first_rvalid_cyc = 0, last_rvalid_cyc = 0, busy_fall_cyc = 0;
    int          t0 = 0;
    logic        skip_edge = 1'b0;
    logic        sck_prev = 1'b0, ce_prev = 1'b1, busy_prev = 1'b0;
    logic [31:0] cmd_sr = '0, last_cmd = '0, first_word = '0, last_word = '0;
    logic [23:0] rd_addr = '0;
    logic [7:0]  fl_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Flash image: each byte is the XOR of its three address bytes, so the
    // first 256 bytes read 00,01,..,FF.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [31:0] model_word(input logic [23:0] a, input int w);
        logic [23:0] base;
        base = (a & ~24'(LINE_WORDS * 4 - 1)) + 24'(4 * w);
        return {flash_byte(base + 24'd3), flash_byte(base + 24'd2),
                flash_byte(base + 24'd1), flash_byte(base)};
    endfunction

    task automatic push_expected(input logic [23:0] a);
        for (int w = 0; w < LINE_WORDS; w++) exp_q.push_back(model_word(a, w));
    endtask

    // ---------------- flash model + monitor + scoreboard ----------------
    always @(negedge HCLK) begin
        if (ce_prev && !bus.ce_n) begin
            ce_falls++;
            last_gap      = hi_run;
            last_gap_busy = hi_busy;
            hi_run        = 0;
            hi_busy       = 0;
            bits_in       = 0;
            out_bit       = 0;
            sck_rises     = 0;
        end
        if (bus.ce_n) begin
            hi_run++;
            if (bus.busy) hi_busy++;
        end
        if (!skip_edge && (bus.ce_n !== ce_prev) && (sck_prev || bus.sck)) bad_ce++;

        if (bus.sck && !sck_prev) begin
            if (bus.ce_n) begin
                bad_sck++;
            end else begin
                sck_rises++;
                if (bits_in < 32) begin
                    cmd_sr = {cmd_sr[30:0], bus.mosi};
                    bits_in++;
                    if (bits_in == 32) begin
                        last_cmd = cmd_sr;
                        rd_addr  = cmd_sr[23:0];
                    end
                end else begin
                    bits_in++;
                end
            end
        end
        if (!bus.sck && sck_prev && !bus.ce_n && bits_in >= 32) begin
            fl_byte  = flash_byte(rd_addr + 24'(out_bit / 8));
            bus.miso = fl_byte[3'(7 - (out_bit % 8))];
            out_bit++;
        end

        if (bus.rvalid) begin
            rvalid_cnt++;
            last_rvalid_cyc = cyc;
            last_word       = bus.rdata;
            if (rvalid_cnt == 1) begin
                first_rvalid_cyc = cyc;
                first_word       = bus.rdata;
            end
            if (exp_q.size() == 0) check("unexpected_rvalid", bus.rdata, 32'hxxxxxxxx);
            else                   check("rdata", bus.rdata, exp_q.pop_front());
        end
        if (bus.done) begin
            done_cnt++;
            check("done_with_rvalid", 32'(bus.rvalid), 32'd1);
        end
        if (busy_prev && !bus.busy) busy_fall_cyc = cyc;

        sck_prev  = bus.sck;
        ce_prev   = bus.ce_n;
        busy_prev = bus.busy;
    end

    // ---------------- driver tasks ----------------
    task automatic start_txn(input logic [23:0] a);
        int guard;
        guard = 0;
        while (bus.busy && guard < 1000) begin
            @(negedge HCLK);
            guard++;
        end
        push_expected(a);
        rvalid_cnt = 0;
        done_cnt   = 0;
        ce_falls   = 0;
        bus.req    = 1'b1;
        bus.addr   = a;
        @(posedge HCLK);
        @(negedge HCLK);
        t0       = cyc;
        bus.req  = 1'b0;
        bus.addr = 24'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (bus.busy && guard < 1000) begin
            @(negedge HCLK);
            guard++;
        end
        if (bus.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, guard);
        end
        @(negedge HCLK);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [23:0] addr;
        logic [31:0] cmd;
        logic [31:0] word0;
        logic [31:0] word3;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [23:0] a;
        int          guard;

        vecs[0] = '{24'h000000, 32'h03000000, 32'h03020100, 32'h0F0E0D0C};
        vecs[1] = '{24'h000013, 32'h03000010, 32'h13121110, 32'h1F1E1D1C};
        vecs[2] = '{24'h0000FF, 32'h030000F0, 32'hF3F2F1F0, 32'hFFFEFDFC};
        vecs[3] = '{24'hFFFFF0, 32'h03FFFFF0, 32'hF3F2F1F0, 32'hFFFEFDFC};
        vecs[4] = '{24'h12345F, 32'h03123450, 32'h75747776, 32'h79787B7A};

        bus.req  = 1'b0;
        bus.addr = '0;
        bus.miso = 1'b0;

        // Reset state.
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_ce_n",   32'(bus.ce_n),   32'd1);
        check("rst_sck",    32'(bus.sck),    32'd0);
        check("rst_mosi",   32'(bus.mosi),   32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_rdata",  bus.rdata,       32'd0);
        check("rst_state",  32'(state),      32'(IDLE));
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Table-driven line reads with fixed expectations and latency.
        for (int i = 0; i < 5; i++) begin
            start_txn(vecs[i].addr);
            wait_idle("tbl_idle");
            check("tbl_cmd",        last_cmd,                  vecs[i].cmd);
            check("tbl_word0",      first_word,                vecs[i].word0);
            check("tbl_word3",      last_word,                 vecs[i].word3);
            check("tbl_sck_rises",  32'(sck_rises),            32'(TOTAL_BITS));
            check("tbl_rvalids",    32'(rvalid_cnt),           32'(LINE_WORDS));
            check("tbl_dones",      32'(done_cnt),             32'd1);
            check("tbl_ce_falls",   32'(ce_falls),             32'd1);
            check("lat_first",      32'(first_rvalid_cyc - t0), 32'(FIRST_LAT));
            check("lat_last",       32'(last_rvalid_cyc - t0),  32'(LAST_LAT));
            check("lat_busy_low",   32'(busy_fall_cyc - t0),    32'(BUSY_LAT));
        end

        // A second req 50 cycles into a transaction is dropped.
        start_txn(24'h000040);
        repeat (50) @(negedge HCLK);
        bus.req  = 1'b1;
        bus.addr = 24'h000080;
        @(negedge HCLK);
        bus.req = 1'b0;
        wait_idle("ign_idle");
        repeat (10) @(negedge HCLK);
        check("ign_dones",    32'(done_cnt),   32'd1);
        check("ign_ce_falls", 32'(ce_falls),   32'd1);
        check("ign_rvalids",  32'(rvalid_cnt), 32'(LINE_WORDS));
        check("ign_busy",     32'(bus.busy),   32'd0);

        // req held high: two back-to-back transactions.
        push_expected(24'h000033);
        push_expected(24'h000033);
        rvalid_cnt = 0;
        done_cnt   = 0;
        ce_falls   = 0;
        bus.req    = 1'b1;
        bus.addr   = 24'h000033;
        guard      = 0;
        while (ce_falls < 2 && guard < 1000) begin
            @(negedge HCLK);
            guard++;
        end
        bus.req = 1'b0;
        wait_idle("b2b_idle");
        check("b2b_ce_falls",  32'(ce_falls),      32'd2);
        check("b2b_dones",     32'(done_cnt),      32'd2);
        check("b2b_rvalids",   32'(rvalid_cnt),    32'(2 * LINE_WORDS));
        // Deselect hold while busy, plus the idle cycle that samples req.
        check("b2b_gap_desel", 32'(last_gap_busy), 32'(CEH_CYCLES));
        check("b2b_gap_total", 32'(last_gap),      32'(CEH_CYCLES + 1));

        // Reset during data word 2 aborts immediately without done.
        start_txn(24'h000020);
        guard = 0;
        while (rvalid_cnt < 1 && guard < 400) begin
            @(negedge HCLK);
            guard++;
        end
        repeat (20) @(negedge HCLK);
        skip_edge = 1'b1;
        #2 HRESETn = 1'b0;
        #1;
        check("abort_ce_n",   32'(bus.ce_n),   32'd1);
        check("abort_sck",    32'(bus.sck),    32'd0);
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_rvalid", 32'(bus.rvalid), 32'd0);
        check("abort_state",  32'(state),      32'(IDLE));
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        exp_q.delete();
        check("abort_dones",   32'(done_cnt),   32'd0);
        check("abort_rvalids", 32'(rvalid_cnt), 32'd1);
        repeat (2) @(negedge HCLK);
        skip_edge = 1'b0;
        start_txn(24'h000020);
        wait_idle("post_abort_idle");
        check("post_abort_word0", first_word, 32'h23222120);
        check("post_abort_dones", 32'(done_cnt), 32'd1);

        // Random line reads against the model.
        for (int r = 0; r < 6; r++) begin
            a = 24'($urandom);
            start_txn(a);
            wait_idle("rnd_idle");
            check("rnd_cmd",     last_cmd,        {CMD_READ, a & ~24'(LINE_WORDS * 4 - 1)});
            check("rnd_dones",   32'(done_cnt),   32'd1);
            check("rnd_rvalids", 32'(rvalid_cnt), 32'(LINE_WORDS));
            check("rnd_lat",     32'(last_rvalid_cyc - t0), 32'(LAST_LAT));
        end

        // Global pin-discipline and scoreboard drain.
        check("sck_while_deselected", 32'(bad_sck),      32'd0);
        check("ce_change_sck_high",   32'(bad_ce),       32'd0);
        check("exp_q_empty",          32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
